// File: rtl/deser_pkg.sv
// Shared helpers for the deserializing gearbox: counter sizing, lane mapping,
// keep-mask generation and the output-slot state type.
package deser_pkg;

  // Largest RATIO the keep_mask helper can describe.
  localparam int unsigned MAX_RATIO = 256;
  localparam int unsigned MAX_LANE_W = 8;

  typedef enum logic {OutEmpty, OutFull} out_st_e;

  // Width of the beat counter: must hold 0..RATIO.
  function automatic int unsigned cnt_w(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  // Lane that beat k of a word lands in.
  function automatic int unsigned lane_of(input int unsigned k, input int unsigned ratio,
                                          input bit msb_first);
    return msb_first ? (ratio - 1 - k) : k;
  endfunction

  // Keep mask for a word holding n beats; bits above ratio stay zero.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned n,
                                                     input int unsigned ratio,
                                                     input bit msb_first);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < MAX_RATIO; k++) begin
      if (k < n && k < ratio) begin
        m[MAX_LANE_W'(lane_of(k, ratio, msb_first))] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/deser_gearbox_if.sv
// Stream bundle around the gearbox: narrow input side (s_*) and wide output side (m_*).
// master: the environment (drives beats, accepts words); slave: the gearbox itself.
interface deser_gearbox_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned RATIO = 16
);
  localparam int unsigned OUT_W = IN_W * RATIO;

  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic [RATIO-1:0] m_keep;
  logic             m_partial;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_partial
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_partial
  );

endinterface

// File: rtl/deser_out_slot.sv
// Output holding register with valid/ready. A load in the same cycle as a consume
// replaces the word and keeps valid high, so the slot sustains one word per cycle.
module deser_out_slot import deser_pkg::*; #(
  parameter int unsigned OUT_W = 128,
  parameter int unsigned RATIO = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic [RATIO-1:0] keep_i,
  input  logic             partial_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o,
  output logic [RATIO-1:0] keep_o,
  output logic             partial_o
);

  out_st_e          st_q, st_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             partial_q, partial_d;

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= OutEmpty;
      data_q    <= '0;
      keep_q    <= '0;
      partial_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      partial_q <= partial_d;
    end
  end

  // Next state: load wins over consume; payload only changes on load so it holds while stalled.
  always_comb begin
    st_d      = st_q;
    data_d    = data_q;
    keep_d    = keep_q;
    partial_d = partial_q;
    unique case (st_q)
      OutEmpty: if (load_i) st_d = OutFull;
      OutFull:  if (!load_i && ready_i) st_d = OutEmpty;
    endcase
    if (load_i) begin
      data_d    = data_i;
      keep_d    = keep_i;
      partial_d = partial_i;
    end
  end

  assign valid_o   = (st_q == OutFull);
  assign data_o    = data_q;
  assign keep_o    = keep_q;
  assign partial_o = partial_q;

endmodule

// File: rtl/deser_gearbox.sv
// Narrow-to-wide deserializer: packs RATIO beats of IN_W bits into one word, with
// s_last flush, lane-keep mask and backpressure on both sides.
// Optional build macro DESER_GEARBOX_STATS_EN adds word/flush counters.
module deser_gearbox import deser_pkg::*; #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DESER_GEARBOX_STATS_EN
  output logic [15:0] word_cnt_o,
  output logic [15:0] flush_cnt_o,
`endif
  deser_gearbox_if.slave bus_io
);

  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned CNT_W = cnt_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if (IN_W < 1 || RATIO < 2 || RATIO > MAX_RATIO) begin : g_bad_param
    $error("deser_gearbox: unsupported IN_W/RATIO");
  end

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic [OUT_W-1:0]     beat_word, word_nxt;
  logic                 completes, beat_ok, load, partial;
  logic [MAX_RATIO-1:0] keep_full;
  logic [RATIO-1:0]     keep;
  logic                 slot_valid;

  // Only completing beats need the slot, so fill beats keep flowing while it is stalled.
  assign completes      = (cnt_q == LAST_CNT) || bus_io.s_last;
  assign bus_io.s_ready = !(slot_valid && !bus_io.m_ready && completes);
  assign beat_ok        = bus_io.s_valid && bus_io.s_ready;
  assign load           = beat_ok && completes;
  assign partial        = bus_io.s_last && (cnt_q != LAST_CNT);

  assign beat_word = OUT_W'(bus_io.s_data) << (lane_of(32'(cnt_q), RATIO, MSB_FIRST) * IN_W);
  assign word_nxt  = acc_q | beat_word;
  assign keep_full = keep_mask(32'(cnt_q) + 32'd1, RATIO, MSB_FIRST);
  assign keep      = keep_full[RATIO-1:0];

  if (RATIO < MAX_RATIO) begin : g_keep_unused
    logic unused_keep_hi;
    assign unused_keep_hi = ^keep_full[MAX_RATIO-1:RATIO];
  end

  // Fill counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  // Advance on fill beats; clear on the completing beat (its data goes straight to the slot).
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (beat_ok) begin
      if (completes) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = word_nxt;
      end
    end
  end

  deser_out_slot #(
    .OUT_W (OUT_W),
    .RATIO (RATIO)
  ) u_out_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .data_i    (word_nxt),
    .keep_i    (keep),
    .partial_i (partial),
    .ready_i   (bus_io.m_ready),
    .valid_o   (slot_valid),
    .data_o    (bus_io.m_data),
    .keep_o    (bus_io.m_keep),
    .partial_o (bus_io.m_partial)
  );

  assign bus_io.m_valid = slot_valid;

`ifdef DESER_GEARBOX_STATS_EN
  logic [15:0] word_cnt_q, flush_cnt_q;

  // Load counters; wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else if (load) begin
      word_cnt_q <= word_cnt_q + 16'd1;
      if (partial) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign word_cnt_o  = word_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_deser_gearbox.sv
// Scoreboard bench: two gearboxes (MSB-first and LSB-first) share one stimulus stream;
// a reference model packs accepted beats into expected words, a monitor checks outputs.
module tb_deser_gearbox;

  localparam int unsigned IW = 8;
  localparam int unsigned R  = 16;
  localparam int unsigned OW = IW * R;

  typedef struct {
    logic [OW-1:0] d;
    logic [R-1:0]  k;
    logic          p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  deser_gearbox_if #(.IN_W(IW), .RATIO(R)) bus0 ();
  deser_gearbox_if #(.IN_W(IW), .RATIO(R)) bus1 ();

  assign bus1.s_valid = bus0.s_valid;
  assign bus1.s_data  = bus0.s_data;
  assign bus1.s_last  = bus0.s_last;
  assign bus1.m_ready = bus0.m_ready;

`ifdef DESER_GEARBOX_STATS_EN
  logic [15:0] wc0, fc0, wc1, fc1;
`endif

  deser_gearbox #(.IN_W(IW), .RATIO(R), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef DESER_GEARBOX_STATS_EN
    .word_cnt_o  (wc0),
    .flush_cnt_o (fc0),
`endif
    .bus_io      (bus0.slave)
  );

  deser_gearbox #(.IN_W(IW), .RATIO(R), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef DESER_GEARBOX_STATS_EN
    .word_cnt_o  (wc1),
    .flush_cnt_o (fc1),
`endif
    .bus_io      (bus1.slave)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   lat_due = -1;
  bit   chk_en = 1'b0;
  bit   rand_rdy = 1'b0;
  logic rdy_fixed = 1'b1;

  logic [IW-1:0] beats[$];
  exp_t          q0[$];
  exp_t          q1[$];
  int            mw = 0;
  int            mf = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of m_ready: fixed level or random backpressure.
  always @(posedge clk) begin
    #1;
    bus0.m_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  // Reference model: collect accepted beats, emit expected words.
  always @(negedge clk) begin
    if (!rst_n) begin
      beats.delete();
      q0.delete();
      q1.delete();
      mw = 0;
      mf = 0;
      lat_due = -1;
    end else if (chk_en) begin
      logic exp_rdy;
      exp_rdy = !(bus0.m_valid && !bus0.m_ready && ((beats.size() == R - 1) || bus0.s_last));
      chk("s_ready_msb", bus0.s_ready, exp_rdy);
      chk("s_ready_lsb", bus1.s_ready, exp_rdy);
`ifdef DESER_GEARBOX_STATS_EN
      chk("word_cnt", wc0, 16'(mw));
      chk("flush_cnt", fc0, 16'(mf));
      chk("word_cnt_lsb", wc1, 16'(mw));
`endif
      if (bus0.s_valid && bus0.s_ready) begin
        beats.push_back(bus0.s_data);
        if (beats.size() == R || bus0.s_last) begin
          exp_t e0, e1;
          int   n;
          logic [31:0] km;
          n = beats.size();
          e0.d = '0;
          for (int k = 0; k < n; k++) e0.d = (e0.d << IW) | OW'(beats[k]);
          e0.d = e0.d << ((R - n) * IW);
          e1.d = '0;
          for (int k = n - 1; k >= 0; k--) e1.d = (e1.d << IW) | OW'(beats[k]);
          km   = (32'd1 << n) - 32'd1;
          e0.k = R'(km << (R - n));
          e1.k = R'(km);
          e0.p = (n < R);
          e1.p = (n < R);
          q0.push_back(e0);
          q1.push_back(e1);
          mw = (mw + 1) & 16'hFFFF;
          if (n < R) mf = (mf + 1) & 16'hFFFF;
          lat_due = cyc + 1;
          beats.delete();
        end
      end
    end
  end

  task automatic mon(input int w, input logic v, input logic r, input logic [OW-1:0] d,
                     input logic [R-1:0] k, input logic p);
    exp_t  e;
    string tag;
    tag = (w == 0) ? "msb" : "lsb";
    if (!v) return;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_word_%s: got %0h expected no word", tag, d);
      return;
    end
    e = (w == 0) ? q0[0] : q1[0];
    chk({"m_data_", tag}, d, e.d);
    chk({"m_keep_", tag}, OW'(k), OW'(e.k));
    chk({"m_partial_", tag}, OW'(p), OW'(e.p));
    if (r) begin
      if (w == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  // Output monitor: compare every presented word with the head of the queue.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (cyc == lat_due) begin
        chk("latency_msb", bus0.m_valid, 1'b1);
        chk("latency_lsb", bus1.m_valid, 1'b1);
      end
      mon(0, bus0.m_valid, bus0.m_ready, bus0.m_data, bus0.m_keep, bus0.m_partial);
      mon(1, bus1.m_valid, bus1.m_ready, bus1.m_data, bus1.m_keep, bus1.m_partial);
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic l);
    bit acc;
    acc = 1'b0;
    bus0.s_valid = 1'b1;
    bus0.s_data  = d;
    bus0.s_last  = l;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clk);
      acc = bus0.s_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got s_ready=0 expected 1 within 1000 cycles");
    end
    bus0.s_valid = 1'b0;
    bus0.s_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_done", OW'(q0.size() + q1.size()), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus0.s_valid = 1'b0;
    bus0.s_data  = '0;
    bus0.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", bus0.m_valid, 1'b0);
    chk("rst_m_data", bus0.m_data, '0);
    chk("rst_m_keep", OW'(bus0.m_keep), '0);
    chk("rst_m_partial", bus0.m_partial, 1'b0);
    chk("rst_s_ready", bus0.s_ready, 1'b1);
    chk("rst_m_valid_lsb", bus1.m_valid, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Full word 0x00..0x0F, back to back.
    for (int i = 0; i < 16; i++) send(IW'(i), 1'b0);
    chk("full_word_msb", bus0.m_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("full_word_lsb", bus1.m_data, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("full_keep_msb", OW'(bus0.m_keep), OW'(16'hFFFF));
    chk("full_partial", bus0.m_partial, 1'b0);
    drain();

    // Five-beat flush, then a full word that must restart at the first lane.
    for (int i = 0; i < 5; i++) send(IW'(8'hA1 + i), (i == 4));
    chk("flush_word_msb", bus0.m_data, 128'hA1A2A3A4A5_0000000000000000000000);
    chk("flush_word_lsb", bus1.m_data, 128'hA5A4A3A2A1);
    chk("flush_keep_msb", OW'(bus0.m_keep), OW'(16'hF800));
    chk("flush_keep_lsb", OW'(bus1.m_keep), OW'(16'h001F));
    chk("flush_partial", bus0.m_partial, 1'b1);
    for (int i = 0; i < 16; i++) send(IW'($urandom), (i == 15));
    drain();

    // Stalled output: 32 beats, second word blocks at its last beat until m_ready rises.
    rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 32; i++) send(IW'(8'h40 + i), 1'b0);
      begin
        repeat (40) @(posedge clk);
        chk("stall_s_ready_low", bus0.s_ready, 1'b0);
        rdy_fixed = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random flushes, gaps and backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
      send(IW'($urandom), ($urandom_range(0, 7) == 0));
    end
    rand_rdy  = 1'b0;
    rdy_fixed = 1'b1;
    drain();

    // Reset with a pending word and a partial accumulator.
    rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 23; i++) send(IW'(i), 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", bus0.m_valid, 1'b0);
    chk("midrst_m_data", bus0.m_data, '0);
    chk("midrst_m_valid_lsb", bus1.m_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n     = 1'b1;
    rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) send(IW'(8'hC0 + i), 1'b0);
    chk("post_rst_word", bus0.m_data, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    chk("post_rst_partial", bus0.m_partial, 1'b0);
    drain();
`ifdef DESER_GEARBOX_STATS_EN
    chk("post_rst_word_cnt", OW'(wc0), OW'(16'd1));
    chk("post_rst_flush_cnt", OW'(fc0), '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deser_gearbox.md
Name: deser_gearbox

Overview:
- Parametrised narrow-to-wide deserializer. Packs RATIO beats of IN_W bits into one OUT_W = IN_W*RATIO word.
- Successor to the fixed 8-to-128 packer feeding the SM4 datapath.
- Adds valid/ready backpressure on both sides, selectable lane order, and partial-word flush with lane-keep mask.
- Sits between the byte-wide host/UART ingress and the 128-bit SM4 block input.

Parameters:
- IN_W, default 8: input beat width in bits; must be ≥1.
- RATIO, default 16: beats per output word; must be ≥2. OUT_W = IN_W*RATIO.
- MSB_FIRST, default 1: 1 = first beat lands in the most significant lane; 0 = first beat lands in lane 0 (LSBs).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  gearbox can accept a beat.
- s_data  in  IN_W  input beat.
- s_last  in  1  beat closes the current word early (flush).
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  OUT_W  packed word.
- m_keep  out  RATIO  per-lane valid mask. Bit i covers m_data[i*IN_W +: IN_W].
- m_partial  out  1  word was closed by s_last before RATIO beats.

Behaviour:
- Reset values: s_ready=1, m_valid=0, m_data=0, m_keep=0, m_partial=0. Lane counter=0, accumulator=0.
- A beat is accepted when s_valid && s_ready. A word is consumed when m_valid && m_ready.
- Lane placement:
  - MSB_FIRST=1: beat k (0-based) goes to lane RATIO-1-k.
  - MSB_FIRST=0: beat k goes to lane k.
- Lane counter width is clog2(RATIO+1). It increments on each accepted beat that does not complete the word.
- Completing beat: an accepted beat with counter==RATIO-1, or with s_last=1. On that beat:
  - The accumulator plus the current beat are loaded into the output register.
  - m_valid=1 from the next cycle (latency 1 cycle from the last beat).
  - Counter and accumulator clear to 0 in the same cycle.
- m_keep: all ones for a full word. For a flush, only lanes 0..n-1 (MSB_FIRST=0) or RATIO-1..RATIO-n (MSB_FIRST=1) are set, where n is the number of beats in the word. Unfilled lanes of m_data read 0.
- m_partial=1 iff the word was closed by s_last with n<RATIO. s_last on beat RATIO-1 is a full word: m_partial=0.
- Holding rules: m_data, m_keep and m_partial stay stable while m_valid && !m_ready. m_valid drops the cycle after consumption unless a new word loads in the same cycle.
- s_ready = !(m_valid && !m_ready && next_beat_completes), where next_beat_completes = (counter==RATIO-1) || s_last.
  - Non-completing beats are still accepted while the output is stalled.
  - s_ready is combinational from m_valid, m_ready, counter and s_last. No path from s_valid to s_ready.
- Simultaneous consume and load in the same cycle: the new word replaces the old one and m_valid stays 1. This gives full throughput of 1 beat per cycle.
- s_valid low: counter and accumulator hold. Idle gaps of any length are allowed mid-word.
- Async reset mid-word discards the partial accumulator and any pending output word.
- State view: FILL(counter 0..RATIO-1) × OUT{EMPTY,FULL}. OUT goes EMPTY→FULL on a completing beat, and FULL→EMPTY on consume without a new load.

Optional Feature:
- Macro DESER_GEARBOX_STATS_EN.
- When defined:
  - Adds output port word_cnt, 16 bits, reset 0.
  - Increments by 1 on each word loaded, full or partial. Wraps 0xFFFF→0x0000.
  - Adds output port flush_cnt, 16 bits: same rules, but counts partial words only.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package deser_pkg holds:
  - CNT_W(RATIO) width function (clog2(RATIO+1)).
  - Lane-index helper lane_of(k, RATIO, MSB_FIRST).
  - keep_mask(n, RATIO, MSB_FIRST) function.
- One natural sub-module: deser_out_slot, the output holding register with valid/ready and load-while-consume logic. The accumulator and counter stay in the top level.

Test Plan:
- Defaults; 16 beats 0x00..0x0F back-to-back, m_ready=1 → one word 0x000102…0E0F, m_keep=0xFFFF, m_partial=0, m_valid 1 cycle after beat 15.
- MSB_FIRST=0, same stimulus → m_data=0x0F0E…0100.
- 5 beats 0xA1..0xA5 with s_last on the 5th → m_data=0xA1A2A3A4A5 followed by 22 zero nibbles, m_keep=0xF800, m_partial=1. The next word starts at lane 15.
- m_ready=0; stream 32 beats → first word held stable, s_ready drops only at beat 31. Raise m_ready → both words delivered in order with no loss or duplication.
- Continuous random s_valid/m_ready over 10,000 beats with random s_last → scoreboard matches packing. When m_ready=1, no throughput bubble is attributable to the gearbox.
- Assert rst_n mid-word (after 7 beats) → m_valid=0, counter=0. The next 16 beats form a clean full word; with DESER_GEARBOX_STATS_EN, word_cnt=1.
